alu_muldiv_sequencer: RTL and testbench
=======================================

Name: alu_muldiv_sequencer

Overview:
- Multi-cycle unsigned multiply/divide engine for the pipelined core's EX stage (RV32M subset: MUL, MULHU, DIVU, REMU).
- Acts as the initiator side of the team's N-bit ALU port set: drives the ALU's A/B/sel every cycle and consumes its Sum and CarryOut.
- Holds no adder of its own; all add/subtract goes through the external ALU instance.
- Stalls the pipeline via busy until done.

Parameters:
- N, 32, operand/result width; must be ≥ 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MUL (low N bits), 01 MULHU (high N bits), 10 DIVU, 11 REMU.
- operand_a  in  N  multiplicand / dividend; captured on accept.
- operand_b  in  N  multiplier / divisor; captured on accept.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse; result valid in the same cycle.
- result  out  N  registered; holds its value until the next completion.
- alu_a  out  N  ALU operand A.
- alu_b  out  N  ALU operand B.
- alu_sel  out  4  ALU select: 0010 ADD, 0110 SUB (A + ~B + 1), 0000 AND.
- alu_sum  in  N  ALU result, combinational from alu_a/alu_b/alu_sel.
- alu_carry  in  1  ALU carry-out; for SUB, 1 means no borrow (A ≥ B).

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, count=0, all working registers 0. A reset in RUN or DONE aborts the operation: no done pulse, result returns to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on start. Latch op, a, b; set count=0.
  - IDLE → DONE on start when op is DIVU/REMU and operand_b==0. Result = all-ones (DIVU) or operand_a (REMU), per the RISC-V spec.
  - RUN → DONE when count==N-1 at the clock edge.
  - DONE → IDLE unconditionally.
- Start handling: start is ignored while busy. start in the DONE cycle is also ignored; the earliest accept is the following cycle.
- Latency:
  - Accepted start at edge E0 gives iterations at edges E1..EN, and done=1 in the cycle after EN (N+1 cycles after accept).
  - Divide-by-zero: done=1 in the cycle after E0.
- Multiply (shift-add):
  - Registers: hi=0, lo=a, mcand=b.
  - Each RUN cycle: alu_a=hi, alu_b=(lo[0] ? mcand : 0), alu_sel=ADD.
  - Update: {hi,lo} ← {alu_carry, alu_sum, lo} >> 1, truncated to 2N bits.
  - After N iterations, {hi,lo} = a*b. MUL returns lo; MULHU returns hi.
- Divide (restoring):
  - Registers: rem=0, quo=a, div=b.
  - Each RUN cycle: shifted = {rem[N-2:0], quo[N-1]} and msb_out = rem[N-1]. Drive alu_a=shifted, alu_b=div, alu_sel=SUB.
  - If msb_out OR alu_carry: rem ← alu_sum and quo ← {quo[N-2:0],1}.
  - Otherwise: rem ← shifted and quo ← {quo[N-2:0],0}.
  - DIVU returns quo; REMU returns rem.
- ALU drive outside RUN: alu_a=0, alu_b=0, alu_sel=AND (0000).
- result is written only on the RUN→DONE edge or the divide-by-zero accept edge.
- count is log2(N) bits wide and does not wrap within an operation.

Decomposition:
- Shared package (alu_pkg):
  - ALU select constants ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_AND=4'b0000, ALU_OR=4'b0001.
  - muldiv op encodings.
  - FSM state encoding.
- Single module; no sub-module. Testbench instantiates the sequencer together with the team's N-bit ALU.

Test Plan:
- MUL 7×6 (N=32): start, op=00 → done exactly 33 cycles after accept, result=0x0000002A, busy high throughout.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → result=0xFFFFFFFE; MUL of the same operands → 0x00000001.
- DIVU 100/7 → 14; REMU 100/7 → 2. Also DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF, which exercises the msb_out path.
- DIVU 5/0 → done 1 cycle after accept, result=0xFFFFFFFF; REMU 5/0 → result=5.
- start asserted mid-RUN with different operands → ignored: original result and timing unchanged, no second done.
- rst asserted at iteration 10 → next cycle busy=0, done=0, result=0. A fresh MUL 3×3 afterwards → 9.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the N-bit ALU port set and the multiply/divide sequencer.
// Holds the ALU select codes, the RV32M op encodings and the sequencer state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/alu_muldiv_sequencer.sv
// Multi-cycle unsigned MUL/MULHU/DIVU/REMU engine that borrows an external ALU for
// every add/subtract, one iteration per cycle, stalling the pipeline through busy.
module alu_muldiv_sequencer
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] operand_a,
  input  logic [N-1:0] operand_b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_sel,
  input  logic [N-1:0] alu_sum,
  input  logic         alu_carry
);

  localparam int CNT_W = (N > 2) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  muldiv_op_t       r_op;
  logic [CNT_W-1:0] r_count;
  // r_acc is hi (multiply) or rem (divide); r_q is lo or quo; r_opb is mcand or div.
  logic [N-1:0]     r_acc;
  logic [N-1:0]     r_q;
  logic [N-1:0]     r_opb;
  logic [N-1:0]     r_result;

  logic             w_is_div;
  logic             w_div0;
  logic             w_last;
  logic [N-1:0]     w_shifted;
  logic             w_take;
  logic [N-1:0]     w_acc_nxt;
  logic [N-1:0]     w_q_nxt;
  logic [N-1:0]     w_result_nxt;

  assign w_is_div  = (r_op == OP_DIVU) || (r_op == OP_REMU);
  assign w_div0    = op[1] && (operand_b == '0);
  assign w_last    = (r_count == CNT_LAST);
  assign w_shifted = {r_acc[N-2:0], r_q[N-1]};

  assign busy   = (r_state != ST_IDLE);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = w_div0 ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ALU drive depends only on registered state, never on the ALU's answer.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_sel = ALU_AND;
    if (r_state == ST_RUN) begin
      if (w_is_div) begin
        alu_a   = w_shifted;
        alu_b   = r_opb;
        alu_sel = ALU_SUB;
      end else begin
        alu_a   = r_acc;
        alu_b   = r_q[0] ? r_opb : '0;
        alu_sel = ALU_ADD;
      end
    end
  end

  always_comb begin
    w_take = 1'b0;
    if (w_is_div) begin
      // A set msb_out means the shifted remainder already exceeds any N-bit divisor.
      w_take    = r_acc[N-1] | alu_carry;
      w_acc_nxt = w_take ? alu_sum : w_shifted;
      w_q_nxt   = {r_q[N-2:0], w_take};
    end else begin
      w_acc_nxt = {alu_carry, alu_sum[N-1:1]};
      w_q_nxt   = {alu_sum[0], r_q[N-1:1]};
    end
    w_result_nxt = ((r_op == OP_MULHU) || (r_op == OP_REMU)) ? w_acc_nxt : w_q_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= OP_MUL;
      r_count  <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_opb    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= muldiv_op_t'(op);
            r_count <= '0;
            r_acc   <= '0;
            r_q     <= operand_a;
            r_opb   <= operand_b;
            if (w_div0) r_result <= op[0] ? operand_a : '1;
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          if (w_last) r_result <= w_result_nxt;
          else        r_count  <= r_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_sequencer.sv
// Bench for alu_muldiv_sequencer wired to a behavioural N-bit ALU: directed table,
// random ops against an arithmetic reference, and start/reset corner sequences.
module tb_alu_muldiv_sequencer;
  import alu_pkg::*;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [N-1:0] operand_a;
  logic [N-1:0] operand_b;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_sel;
  logic [N-1:0] alu_sum;
  logic         alu_carry;

  always #5 clk = ~clk;

  alu_muldiv_sequencer #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_sum   (alu_sum),
    .alu_carry (alu_carry)
  );

  // Team ALU behaviour.
  always_comb begin
    alu_sum   = '0;
    alu_carry = 1'b0;
    case (alu_sel)
      ALU_ADD: {alu_carry, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b};
      ALU_SUB: {alu_carry, alu_sum} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
      ALU_AND: alu_sum = alu_a & alu_b;
      ALU_OR:  alu_sum = alu_a | alu_b;
      default: ;
    endcase
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_model(input logic [1:0] o, input logic [N-1:0] x,
                                             input logic [N-1:0] y);
    logic [2*N-1:0] p;
    p = 64'(x) * 64'(y);
    case (o)
      2'b00:   return p[N-1:0];
      2'b01:   return p[2*N-1:N];
      2'b10:   return (y == '0) ? '1 : x / y;
      default: return (y == '0) ? x : x % y;
    endcase
  endfunction

  // Issues one op, returns the result and the number of edges after the accept edge
  // at which done was first seen (-1 on timeout).
  task automatic run_op(input logic [1:0] o, input logic [N-1:0] x, input logic [N-1:0] y,
                        output logic [N-1:0] res, output int lat);
    logic busy_drop;
    @(negedge clk);
    start = 1'b1; op = o; operand_a = x; operand_b = y;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_drop = 1'b0;
    if (done) lat = 0;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done) lat = k;
      else if (!busy) busy_drop = 1'b1;
    end
    res = result;
    check("busy_held", N'(busy_drop), '0);
    @(posedge clk); #1;
    check("done_pulse_end", N'({done, busy}), '0);
  endtask

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp;
    int           lat;
  } vec_t;

  vec_t         tbl[8];
  logic [N-1:0] res;
  int           lat;
  int           ndone;
  int           first_lat;
  logic [N-1:0] first_res;

  initial begin
    tbl[0] = '{"mul_7x6",      2'b00, 32'd7,        32'd6,        32'h0000002A, N};
    tbl[1] = '{"mulhu_ffxff",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, N};
    tbl[2] = '{"mul_ffxff",    2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, N};
    tbl[3] = '{"divu_100_7",   2'b10, 32'd100,      32'd7,        32'd14,       N};
    tbl[4] = '{"remu_100_7",   2'b11, 32'd100,      32'd7,        32'd2,        N};
    tbl[5] = '{"divu_ff_1",    2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, N};
    tbl[6] = '{"divu_5_0",     2'b10, 32'd5,        32'd0,        32'hFFFFFFFF, 0};
    tbl[7] = '{"remu_5_0",     2'b11, 32'd5,        32'd0,        32'd5,        0};

    rst = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", N'(busy), '0);
    check("reset_done", N'(done), '0);
    check("reset_result", result, '0);
    check("reset_alu_sel", N'(alu_sel), N'(ALU_AND));
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, res, lat);
      check({tbl[i].name, "_result"}, res, tbl[i].exp);
      check({tbl[i].name, "_latency"}, N'(lat), N'(tbl[i].lat));
    end

    for (int i = 0; i < 40; i++) begin
      logic [1:0]   o;
      logic [N-1:0] x;
      logic [N-1:0] y;
      int           sel;
      o   = 2'($urandom_range(0, 3));
      x   = $urandom;
      sel = $urandom_range(0, 5);
      y   = (sel == 0) ? '0 : (sel == 1) ? N'($urandom_range(1, 15)) : N'($urandom);
      run_op(o, x, y, res, lat);
      check("rand_result", res, ref_model(o, x, y));
      check("rand_latency", N'(lat), N'((o[1] && y == '0) ? 0 : N));
    end

    // Start mid-run is ignored; start in the DONE cycle is ignored, accepted one cycle later.
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'd7; operand_b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0; first_lat = -1; first_res = '0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (first_lat < 0) begin
          first_lat = k;
          first_res = result;
        end
      end
      if (k == first_lat + 1) check("start_in_done_ignored", N'(busy), '0);
      if (k == first_lat + 2) check("start_after_done_accepted", N'(busy), 32'd1);
      if (k >= 5 && k <= 8) begin
        start = 1'b1; op = 2'b10; operand_a = 32'd100; operand_b = 32'd0;
      end else if (first_lat > 0 && k >= first_lat && k <= first_lat + 1) begin
        start = 1'b1; op = 2'b00; operand_a = 32'd2; operand_b = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    check("midrun_latency", N'(first_lat), N'(N));
    check("midrun_result", first_res, 32'h0000002A);
    check("midrun_done_count", N'(ndone), 32'd2);
    check("second_result_held", result, 32'd10);

    // Reset at iteration 10 aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'd5; operand_b = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_no_done", N'(ndone), '0);
    check("abort_busy", N'(busy), '0);
    check("abort_done", N'(done), '0);
    check("abort_result", result, '0);
    rst = 1'b0;
    run_op(2'b00, 32'd3, 32'd3, res, lat);
    check("after_abort_mul_3x3", res, 32'd9);
    check("after_abort_latency", N'(lat), N'(N));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
